// File: rtl/peach_mem.sv
// peach_mem: word-organised RAM responder with valid/ready request and response channels.
// Defining PEACH_MEM_ALIGN_CHECK_EN adds misalignment faults, evaluated at commit.
module peach_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept, commit;
    logic          c_we;
    logic [31:0]   c_addr, c_wdata;
    logic [3:0]    c_be;
    logic [AW-1:0] c_idx;
    logic          c_range, c_align, c_ok;

    assign accept = req_valid && (state_q == StIdle);
    // With zero wait the commit happens on the accepting edge, straight from the request inputs.
    assign commit = ((state_q == StWait) && (cnt_q == 4'd1)) || (accept && (WAIT_CYCLES == 0));

    assign c_we    = (state_q == StIdle) ? req_we    : we_q;
    assign c_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    assign c_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
    assign c_be    = (state_q == StIdle) ? req_be    : be_q;
    assign c_idx   = c_addr[AW+1:2];
    assign c_range = (c_addr >> (AW + 2)) == 32'd0;
    assign c_ok    = c_range && c_align;

`ifdef PEACH_MEM_ALIGN_CHECK_EN
    always_comb begin
        c_align = 1'b0;
        if (!c_we) begin
            c_align = (c_addr[1:0] == 2'b00);
        end else begin
            case (c_be)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: c_align = 1'b1;
                4'b0011, 4'b1100:                   c_align = ~c_addr[0];
                4'b1111:                            c_align = (c_addr[1:0] == 2'b00);
                default:                            c_align = 1'b0;
            endcase
        end
    end
`else
    logic unused_addr_lsb;
    assign c_align         = 1'b1;
    assign unused_addr_lsb = ^c_addr[1:0];
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cnt_d   = WaitInit;
                    state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            rdata_d = (c_ok && !c_we) ? mem[c_idx] : 32'd0;
            err_d   = !c_ok;
        end else if ((state_q == StResp) && rsp_ready) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; reset only blocks a commit in flight.
    always_ff @(posedge clk) begin
        if (reset && commit && c_we && c_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_peach_mem.sv
// Self-checking bench for peach_mem: per-cycle comparison against a transaction-level memory model.
module tb_peach_mem;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    peach_mem #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          idx;
        logic [31:0] old;
    } exp_t;

    logic [31:0] mem_m [DEPTH];
    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          cur_lat;
    logic        seen = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Transaction-level model: applies the whole access at acceptance.
    function automatic exp_t model(logic we, logic [31:0] addr, logic [31:0] wd, logic [3:0] be,
                                   int acc);
        exp_t e;
        logic ok;
        int   idx;
        ok = addr < 32'(DEPTH * 4);
`ifdef PEACH_MEM_ALIGN_CHECK_EN
        if (!we) ok = ok && (addr[1:0] == 2'b00);
        else if (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) ok = ok;
        else if (be inside {4'b0011, 4'b1100}) ok = ok && !addr[0];
        else if (be == 4'b1111) ok = ok && (addr[1:0] == 2'b00);
        else ok = 1'b0;
`endif
        idx     = ok ? int'(addr >> 2) : 0;
        e.idx   = idx;
        e.old   = mem_m[idx];
        e.acc   = acc;
        e.err   = !ok;
        e.rdata = 32'd0;
        if (ok && we) begin
            for (int i = 0; i < 4; i++) if (be[i]) mem_m[idx][8*i +: 8] = wd[8*i +: 8];
        end else if (ok) begin
            e.rdata = mem_m[idx];
        end
        return e;
    endfunction

    always @(negedge clk) begin : cmp
        logic ev;
        if (reset) begin
            ev = (q.size() > 0) && (cyc >= q[0].acc + int'(W));
            chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, q[0].rdata);
                chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
                if (!seen) begin
                    cur_lat = cyc + 1 - q[0].acc;
                    seen    = 1'b1;
                end
                if (rsp_ready) begin
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    last_lat   = cur_lat;
                    seen       = 1'b0;
                    void'(q.pop_front());
                    done_cnt++;
                end
            end else begin
                chk("rsp_rdata_idle", rsp_rdata, 32'd0);
                chk("rsp_err_idle", 32'(rsp_err), 32'd0);
            end
            if (req_valid && req_ready) q.push_back(model(req_we, req_addr, req_wdata, req_be, cyc + 1));
        end
    end

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
        int d0;
        int t;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = (hold == 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 100);
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (hold > 0) begin
            repeat (int'(W) + hold) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
        end
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) chk("response_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] wd);
        int t;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = 4'b1111;
        rsp_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 100);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        // Undo the model's write when the DUT has not yet reached its commit edge.
        if (q.size() > 0 && cyc < q[0].acc + int'(W)) mem_m[q[0].idx] = q[0].old;
        q.delete();
        seen = 1'b0;
        @(negedge clk);
        chk("mid_reset_req_ready", 32'(req_ready), 32'd1);
        chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [31:0] a;
        int r;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) txn(1'b1, 32'(i * 4), $urandom, 4'b1111, 0);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
        chk("wr_0x10_lat", 32'(last_lat), 32'd2);
        chk("wr_0x10_err", 32'(last_err), 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'b0000, 0);
        chk("rd_0x10_data", last_rdata, 32'hDEADBEEF);
        chk("rd_0x10_err", 32'(last_err), 32'd0);
        chk("rd_0x10_lat", 32'(last_lat), 32'd2);

        txn(1'b1, 32'h10, 32'h11223344, 4'b1111, 0);
        txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1);
        chk("be0001_wr_data", last_rdata, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'b1111, 0);
        chk("be0001_rd_data", last_rdata, 32'h112233AA);

        txn(1'b1, 32'h0FFC, 32'hCAFEF00D, 4'b1111, 0);
        txn(1'b0, 32'(DEPTH * 4), 32'd0, 4'b0000, 0);
        chk("oor_rd_err", 32'(last_err), 32'd1);
        chk("oor_rd_data", last_rdata, 32'd0);
        txn(1'b1, 32'(DEPTH * 4), 32'h0BADF00D, 4'b1111, 0);
        chk("oor_wr_err", 32'(last_err), 32'd1);
        txn(1'b0, 32'h0FFC, 32'd0, 4'b0000, 0);
        chk("top_word_data", last_rdata, 32'hCAFEF00D);
        chk("top_word_err", 32'(last_err), 32'd0);

        d0 = done_cnt;
        txn(1'b0, 32'h10, 32'd0, 4'b0000, 5);
        repeat (3) @(negedge clk);
        chk("hold_one_done", 32'(done_cnt - d0), 32'd1);
        chk("hold_rdata", last_rdata, 32'h112233AA);

        txn(1'b1, 32'h20, 32'h55AA55AA, 4'b1111, 0);
        reset_mid_write(32'h20, 32'h12345678);
        txn(1'b0, 32'h20, 32'd0, 4'b0000, 0);
        chk("mid_reset_old_data", last_rdata, 32'h55AA55AA);

        txn(1'b0, 32'h22, 32'd0, 4'b0000, 0);
`ifdef PEACH_MEM_ALIGN_CHECK_EN
        chk("rd_0x22_err", 32'(last_err), 32'd1);
        chk("rd_0x22_data", last_rdata, 32'd0);
`else
        chk("rd_0x22_err", 32'(last_err), 32'd0);
        chk("rd_0x22_data", last_rdata, 32'h55AA55AA);
`endif
        txn(1'b1, 32'h22, 32'hA5B60000, 4'b1100, 0);
        chk("wr_0x22_be1100_err", 32'(last_err), 32'd0);
        txn(1'b0, 32'h20, 32'd0, 4'b0000, 0);
        chk("rd_0x20_merged", last_rdata, 32'hA5B655AA);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            else if (r == 1) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH * 4 - 1));
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
        end
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
